// File: rtl/simple_iq_dispatch_ctrl_if.sv
// Rename-to-IQ dispatch bus: the rename group offer, the free-entry counts
// coming back from the two simple IQs, and the per-IQ write ports.
interface simple_iq_dispatch_ctrl_if #(
    parameter int INFO_W = 128
);
    logic              rename_valid;
    logic [2:0]        rename_instr_num;
    logic [INFO_W-1:0] rename_instr_info [3:0];
    logic              rename_ready;

    logic [2:0]        iq0_left_cnt;
    logic [2:0]        iq1_left_cnt;

    logic              iq0_valid;
    logic [2:0]        iq0_instr_num;
    logic [INFO_W-1:0] iq0_instr_info [3:0];
    logic              iq1_valid;
    logic [2:0]        iq1_instr_num;
    logic [INFO_W-1:0] iq1_instr_info [3:0];

    // Environment side: rename stage plus the IQ occupancy feedback.
    modport master (
        output rename_valid, rename_instr_num, rename_instr_info,
        output iq0_left_cnt, iq1_left_cnt,
        input  rename_ready,
        input  iq0_valid, iq0_instr_num, iq0_instr_info,
        input  iq1_valid, iq1_instr_num, iq1_instr_info
    );

    // Dispatch controller side.
    modport slave (
        input  rename_valid, rename_instr_num, rename_instr_info,
        input  iq0_left_cnt, iq1_left_cnt,
        output rename_ready,
        output iq0_valid, iq0_instr_num, iq0_instr_info,
        output iq1_valid, iq1_instr_num, iq1_instr_info
    );
endinterface

// File: rtl/simple_iq_dispatch_ctrl.sv
// Simple IQ dispatch controller: buffers one rename group and splits it
// across two simple issue queues, favouring the round-robin preferred IQ.
// A group dispatches whole or not at all.
module simple_iq_dispatch_ctrl #(
    parameter int INFO_W = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    simple_iq_dispatch_ctrl_if.slave  dif,
    output logic [15:0]               stall_cnt
);

    logic              buf_valid_q, buf_valid_d;
    logic [2:0]        buf_num_q, buf_num_d;
    logic [INFO_W-1:0] buf_info_q [3:0];
    logic [INFO_W-1:0] buf_info_d [3:0];
    logic              rr_ptr_q, rr_ptr_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;

    logic [2:0]        left_p, left_o;
    logic [3:0]        sum_left;
    logic [2:0]        k_p, k_o;
    logic [2:0]        num_p, num_o;
    logic              fire;
    logic              rename_ready;
    logic              accept;
    logic [INFO_W-1:0] p_info [3:0];
    logic [INFO_W-1:0] o_info [3:0];

    // Dispatch decision and split between preferred (P) and other (O) IQ.
    // The split starts balanced (P gets the odd one) and is then clamped
    // by each IQ's free entries; the fire check guarantees it fits.
    always_comb begin
        left_p   = rr_ptr_q ? dif.iq1_left_cnt : dif.iq0_left_cnt;
        left_o   = rr_ptr_q ? dif.iq0_left_cnt : dif.iq1_left_cnt;
        sum_left = {1'b0, left_p} + {1'b0, left_o};
        fire     = buf_valid_q && !flush && (sum_left >= {1'b0, buf_num_q});
        k_p      = (buf_num_q + 3'd1) >> 1;
        k_o      = buf_num_q - k_p;
        if (k_p > left_p) begin
            k_p = left_p;
            k_o = buf_num_q - left_p;
        end
        if (k_o > left_o) begin
            k_o = left_o;
            k_p = buf_num_q - left_o;
        end
        num_p = fire ? k_p : 3'd0;
        num_o = fire ? k_o : 3'd0;
    end

    // Pack payloads: first num_p slots to P, the remainder to O from slot 0.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            p_info[i] = '0;
            o_info[i] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < num_p) p_info[i] = buf_info_q[i];
            if (3'(i) < num_o) o_info[i] = buf_info_q[2'(num_p + 3'(i))];
        end
    end

    // Map P/O onto the physical IQ ports according to rr_ptr.
    always_comb begin
        dif.iq0_instr_num = rr_ptr_q ? num_o : num_p;
        dif.iq1_instr_num = rr_ptr_q ? num_p : num_o;
        dif.iq0_valid     = dif.iq0_instr_num != 3'd0;
        dif.iq1_valid     = dif.iq1_instr_num != 3'd0;
        for (int i = 0; i < 4; i++) begin
            dif.iq0_instr_info[i] = rr_ptr_q ? o_info[i] : p_info[i];
            dif.iq1_instr_info[i] = rr_ptr_q ? p_info[i] : o_info[i];
        end
    end

    assign rename_ready     = !flush && (!buf_valid_q || fire);
    assign accept           = dif.rename_valid && rename_ready;
    assign dif.rename_ready = rename_ready;
    assign stall_cnt        = stall_cnt_q;

    // Next buffer, pointer and stall-counter state; flush empties the
    // buffer but leaves rr_ptr and stall_cnt alone.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_num_d   = buf_num_q;
        buf_info_d  = buf_info_q;
        rr_ptr_d    = rr_ptr_q ^ (fire && buf_num_q[0]);
        stall_cnt_d = stall_cnt_q;
        if (buf_valid_q && !fire && !flush && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (flush) begin
            buf_valid_d = 1'b0;
        end else if (accept) begin
            buf_valid_d = 1'b1;
            buf_num_d   = dif.rename_instr_num;
            buf_info_d  = dif.rename_instr_info;
        end else if (fire) begin
            buf_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_num_q   <= 3'd0;
            rr_ptr_q    <= 1'b0;
            stall_cnt_q <= 16'd0;
            for (int i = 0; i < 4; i++) buf_info_q[i] <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_num_q   <= buf_num_d;
            rr_ptr_q    <= rr_ptr_d;
            stall_cnt_q <= stall_cnt_d;
            buf_info_q  <= buf_info_d;
        end
    end

endmodule

// File: tb/tb_simple_iq_dispatch_ctrl.sv
// Testbench for simple_iq_dispatch_ctrl: a group-level model checked every
// cycle, plus literal expectations for the key dispatch scenarios.
module tb_simple_iq_dispatch_ctrl;
    localparam int W = 128;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] stall_cnt;

    simple_iq_dispatch_ctrl_if #(.INFO_W(W)) dif ();

    simple_iq_dispatch_ctrl #(.INFO_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .dif       (dif),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [W-1:0] mk(input int g, input int s);
        logic [W-1:0] v;
        v = (W'(g) << 16) | W'(s) | (W'(1) << (W - 1));
        return v;
    endfunction

    // ---------------- group-level model ----------------
    bit           m_init = 1'b0;
    bit           m_valid;
    int           m_num;
    logic [W-1:0] m_info [4];
    int           m_rr;
    int           m_stall;
    bit           e_fire;
    bit           e_ready;
    int           e_k [2];

    // Legal split range for P is [n-b, a] within [0, n]; pick the value in
    // that range closest to ceil(n/2).
    function automatic void model_eval();
        int l [2];
        int a, b, lo, hi, kp;
        l[0] = int'(dif.iq0_left_cnt);
        l[1] = int'(dif.iq1_left_cnt);
        a = l[m_rr];
        b = l[1 - m_rr];
        e_fire = m_valid && !flush && (a + b >= m_num);
        e_k[0] = 0;
        e_k[1] = 0;
        if (e_fire) begin
            lo = (m_num > b) ? m_num - b : 0;
            hi = (a < m_num) ? a : m_num;
            kp = (m_num + 1) / 2;
            if (kp < lo) kp = lo;
            if (kp > hi) kp = hi;
            e_k[m_rr]     = kp;
            e_k[1 - m_rr] = m_num - kp;
        end
        e_ready = !flush && (!m_valid || e_fire);
    endfunction

    function automatic logic [W-1:0] exp_info(input int q, input int s);
        int base;
        if (s >= e_k[q]) return '0;
        base = (q == m_rr) ? 0 : e_k[m_rr];
        return m_info[base + s];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1'b0;
            m_rr    = 0;
            m_stall = 0;
            m_num   = 0;
            m_init  = 1'b1;
        end else if (m_init) begin
            model_eval();
            if (flush) begin
                m_valid = 1'b0;
            end else begin
                if (m_valid && !e_fire && m_stall < 65535) m_stall++;
                if (e_fire && (m_num % 2 == 1)) m_rr = 1 - m_rr;
                if (dif.rename_valid && e_ready) begin
                    m_valid = 1'b1;
                    m_num   = int'(dif.rename_instr_num);
                    for (int s = 0; s < 4; s++) m_info[s] = dif.rename_instr_info[s];
                end else if (e_fire) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            model_eval();
            chk("rename_ready", W'(dif.rename_ready), W'(e_ready));
            chk("stall_cnt", W'(stall_cnt), W'(m_stall));
            chk("iq0_valid", W'(dif.iq0_valid), W'(e_k[0] > 0));
            chk("iq1_valid", W'(dif.iq1_valid), W'(e_k[1] > 0));
            chk("iq0_num", W'(dif.iq0_instr_num), W'(e_k[0]));
            chk("iq1_num", W'(dif.iq1_instr_num), W'(e_k[1]));
            for (int s = 0; s < 4; s++) begin
                chk($sformatf("iq0_info%0d", s), dif.iq0_instr_info[s], exp_info(0, s));
                chk($sformatf("iq1_info%0d", s), dif.iq1_instr_info[s], exp_info(1, s));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic offer(input int num, input int g);
        dif.rename_valid     = 1'b1;
        dif.rename_instr_num = 3'(num);
        for (int s = 0; s < 4; s++)
            dif.rename_instr_info[s] = (s < num) ? mk(g, s) : mk(99, s);
    endtask

    task automatic idle();
        dif.rename_valid = 1'b0;
    endtask

    task automatic set_left(input int l0, input int l1);
        dif.iq0_left_cnt = 3'(l0);
        dif.iq1_left_cnt = 3'(l1);
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        idle();
        dif.rename_instr_num = 3'd1;
        for (int s = 0; s < 4; s++) dif.rename_instr_info[s] = '0;
        set_left(5, 5);
        step();
        step();
        rst = 1'b0;
        settle();

        // Reset state
        chk("rst_ready", W'(dif.rename_ready), W'(1));
        chk("rst_iq0_valid", W'(dif.iq0_valid), W'(0));
        chk("rst_iq1_valid", W'(dif.iq1_valid), W'(0));
        chk("rst_iq0_num", W'(dif.iq0_instr_num), W'(0));
        chk("rst_iq1_num", W'(dif.iq1_instr_num), W'(0));
        chk("rst_iq0_info0", dif.iq0_instr_info[0], '0);
        chk("rst_iq1_info3", dif.iq1_instr_info[3], '0);
        chk("rst_stall", W'(stall_cnt), W'(0));

        // 4-instr group, 5/5, rr=0 -> 2/2
        offer(4, 1);
        step();
        idle();
        settle();
        chk("g4_iq0_num", W'(dif.iq0_instr_num), W'(2));
        chk("g4_iq1_num", W'(dif.iq1_instr_num), W'(2));
        chk("g4_iq0_i0", dif.iq0_instr_info[0], mk(1, 0));
        chk("g4_iq0_i1", dif.iq0_instr_info[1], mk(1, 1));
        chk("g4_iq1_i0", dif.iq1_instr_info[0], mk(1, 2));
        chk("g4_iq1_i1", dif.iq1_instr_info[1], mk(1, 3));
        chk("g4_iq0_i2", dif.iq0_instr_info[2], '0);
        step();

        // Three back-to-back groups of 3 -> 2/1, 1/2, 2/1 (rr still 0)
        offer(3, 2);
        step();
        offer(3, 3);
        settle();
        chk("b2b1_ready", W'(dif.rename_ready), W'(1));
        chk("b2b1_iq0_num", W'(dif.iq0_instr_num), W'(2));
        chk("b2b1_iq1_num", W'(dif.iq1_instr_num), W'(1));
        chk("b2b1_iq1_i0", dif.iq1_instr_info[0], mk(2, 2));
        step();
        offer(3, 4);
        settle();
        chk("b2b2_ready", W'(dif.rename_ready), W'(1));
        chk("b2b2_iq0_num", W'(dif.iq0_instr_num), W'(1));
        chk("b2b2_iq1_num", W'(dif.iq1_instr_num), W'(2));
        chk("b2b2_iq1_i0", dif.iq1_instr_info[0], mk(3, 0));
        chk("b2b2_iq0_i0", dif.iq0_instr_info[0], mk(3, 2));
        step();
        idle();
        settle();
        chk("b2b3_ready", W'(dif.rename_ready), W'(1));
        chk("b2b3_iq0_num", W'(dif.iq0_instr_num), W'(2));
        chk("b2b3_iq1_num", W'(dif.iq1_instr_num), W'(1));
        chk("b2b3_iq0_i1", dif.iq0_instr_info[1], mk(4, 1));
        step();

        // rr is 1 now; a single instr goes to iq1 and brings rr back to 0
        offer(1, 5);
        step();
        idle();
        settle();
        chk("one_iq1_num", W'(dif.iq1_instr_num), W'(1));
        chk("one_iq0_valid", W'(dif.iq0_valid), W'(0));
        step();

        // 4-instr group, iq0=1, iq1=5 -> 1/3
        set_left(1, 5);
        offer(4, 6);
        step();
        idle();
        settle();
        chk("lim_iq0_num", W'(dif.iq0_instr_num), W'(1));
        chk("lim_iq1_num", W'(dif.iq1_instr_num), W'(3));
        chk("lim_iq0_i0", dif.iq0_instr_info[0], mk(6, 0));
        chk("lim_iq1_i0", dif.iq1_instr_info[0], mk(6, 1));
        chk("lim_iq1_i2", dif.iq1_instr_info[2], mk(6, 3));
        chk("lim_iq1_i3", dif.iq1_instr_info[3], '0);
        step();

        // Stall 3 cycles with 1/2, then iq1=3 -> 1/3 dispatch
        set_left(1, 2);
        offer(4, 7);
        step();
        idle();
        settle();
        chk("stl_iq0_valid", W'(dif.iq0_valid), W'(0));
        chk("stl_iq1_valid", W'(dif.iq1_valid), W'(0));
        chk("stl_ready", W'(dif.rename_ready), W'(0));
        step();
        step();
        step();
        set_left(1, 3);
        settle();
        chk("stl_cnt3", W'(stall_cnt), W'(3));
        chk("stl_go_ready", W'(dif.rename_ready), W'(1));
        chk("stl_go_iq0_num", W'(dif.iq0_instr_num), W'(1));
        chk("stl_go_iq1_num", W'(dif.iq1_instr_num), W'(3));
        chk("stl_go_iq1_i2", dif.iq1_instr_info[2], mk(7, 3));
        step();

        // Flush while stalled with a new group offered
        set_left(1, 2);
        offer(4, 8);
        step();
        offer(2, 9);
        flush = 1'b1;
        settle();
        chk("fl_ready", W'(dif.rename_ready), W'(0));
        chk("fl_iq0_valid", W'(dif.iq0_valid), W'(0));
        step();
        flush = 1'b0;
        idle();
        set_left(5, 5);
        settle();
        chk("fl_after_ready", W'(dif.rename_ready), W'(1));
        chk("fl_after_iq0_num", W'(dif.iq0_instr_num), W'(0));
        chk("fl_after_iq1_num", W'(dif.iq1_instr_num), W'(0));
        chk("fl_after_stall", W'(stall_cnt), W'(3));
        offer(1, 10);
        step();
        idle();
        settle();
        chk("fl_rr_iq0_num", W'(dif.iq0_instr_num), W'(1));
        chk("fl_rr_iq1_valid", W'(dif.iq1_valid), W'(0));
        step();

        // Mixed vectors: varying sizes and left counts, rename always offering
        for (int i = 0; i < 24; i++) begin
            set_left((i * 5) % 6, (i + 2) % 6);
            offer((i % 4) + 1, 40 + i);
            step();
        end
        idle();
        set_left(5, 5);
        step();
        step();

        // Saturating stall, then reset mid-stall
        set_left(1, 2);
        offer(4, 11);
        step();
        idle();
        repeat (70000) step();
        settle();
        chk("sat_stall", W'(stall_cnt), W'(16'hFFFF));
        chk("sat_ready", W'(dif.rename_ready), W'(0));
        rst = 1'b1;
        step();
        rst = 1'b0;
        settle();
        chk("rst2_stall", W'(stall_cnt), W'(0));
        chk("rst2_ready", W'(dif.rename_ready), W'(1));
        chk("rst2_iq0_valid", W'(dif.iq0_valid), W'(0));
        chk("rst2_iq1_valid", W'(dif.iq1_valid), W'(0));
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
